// File: rtl/key_debounce_scan.sv
// key_debounce_scan: synchronizes, debounces and edge-detects KEY_NUM active-low keys.
// Optional auto-repeat of KEY_PRESS while a key stays held: define KEY_REPEAT_EN.
`default_nettype none

module key_debounce_scan #(
  parameter int KEY_NUM            = 8,
  parameter int TICK_CYCLES        = 50000,
  parameter int DEBOUNCE_TICKS     = 20,
  parameter int REPEAT_DELAY_TICKS = 500,
  parameter int REPEAT_RATE_TICKS  = 100
) (
  input  logic               CLK_50M,
  input  logic               RST,
  input  logic [KEY_NUM-1:0] KEY,
  output logic [KEY_NUM-1:0] KEY_STATE,
  output logic [KEY_NUM-1:0] KEY_PRESS,
  output logic [KEY_NUM-1:0] KEY_RELEASE,
  output logic               KEY_ANY
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int CW = (DEBOUNCE_TICKS > 0) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
  localparam logic [TW-1:0] c_TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] c_DEB_LAST  = CW'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    ST_UP       = 2'd0,
    ST_CHK_DOWN = 2'd1,
    ST_DOWN     = 2'd2,
    ST_CHK_UP   = 2'd3
  } state_t;

  if (DEBOUNCE_TICKS < 1) begin : g_chk_debounce
    $error("DEBOUNCE_TICKS must be at least 1");
  end
  if (TICK_CYCLES < 2) begin : g_chk_tick
    $error("TICK_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY_TICKS < 1 || REPEAT_RATE_TICKS < 1) begin : g_chk_repeat
    $error("REPEAT_DELAY_TICKS and REPEAT_RATE_TICKS must be at least 1");
  end

  logic [KEY_NUM-1:0] r_sync1;
  logic [KEY_NUM-1:0] r_sync2;
  logic [KEY_NUM-1:0] w_s;
  logic [TW-1:0]      r_tick_cnt;
  logic               w_tick;
  logic [KEY_NUM-1:0] w_level_nxt;
  logic [KEY_NUM-1:0] w_press_vec;
  logic [KEY_NUM-1:0] w_release_vec;

  // Synchronizers reset to the released level so no spurious press follows reset.
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= KEY;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = ~r_sync2;

  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  assign w_tick = (r_tick_cnt == c_TICK_LAST);

  for (genvar gi = 0; gi < KEY_NUM; gi++) begin : g_key
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_press;
    logic          w_release;

    always_ff @(posedge CLK_50M or posedge RST) begin
      if (RST) begin
        r_state <= ST_UP;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    // A level mismatch is checked before the tick, so an abort discards a coincident tick.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_press     = 1'b0;
      w_release   = 1'b0;
      case (r_state)
        ST_UP: begin
          if (w_s[gi]) begin
            w_state_nxt = ST_CHK_DOWN;
            w_cnt_nxt   = '0;
          end
        end
        ST_CHK_DOWN: begin
          if (!w_s[gi]) begin
            w_state_nxt = ST_UP;
            w_cnt_nxt   = '0;
          end else if (w_tick) begin
            if (r_cnt == c_DEB_LAST) begin
              w_state_nxt = ST_DOWN;
              w_cnt_nxt   = '0;
              w_press     = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end
        end
        ST_DOWN: begin
          if (!w_s[gi]) begin
            w_state_nxt = ST_CHK_UP;
            w_cnt_nxt   = '0;
          end
        end
        ST_CHK_UP: begin
          if (w_s[gi]) begin
            w_state_nxt = ST_DOWN;
            w_cnt_nxt   = '0;
          end else if (w_tick) begin
            if (r_cnt == c_DEB_LAST) begin
              w_state_nxt = ST_UP;
              w_cnt_nxt   = '0;
              w_release   = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end
        end
        default: begin
          w_state_nxt = ST_UP;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    assign w_level_nxt[gi]   = (w_state_nxt == ST_DOWN) || (w_state_nxt == ST_CHK_UP);
    assign w_release_vec[gi] = w_release;

`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY_TICKS + REPEAT_RATE_TICKS + 1);
    localparam logic [RW-1:0] c_RPT_DELAY = RW'(REPEAT_DELAY_TICKS);
    localparam logic [RW-1:0] c_RPT_WRAP  = RW'(REPEAT_DELAY_TICKS + REPEAT_RATE_TICKS);

    logic [RW-1:0] r_rpt;
    logic [RW-1:0] w_rpt_nxt;
    logic [RW-1:0] w_rpt_inc;
    logic          w_rpt_pulse;

    assign w_rpt_inc = r_rpt + RW'(1);

    always_ff @(posedge CLK_50M or posedge RST) begin
      if (RST) begin
        r_rpt <= '0;
      end else begin
        r_rpt <= w_rpt_nxt;
      end
    end

    // Only a fresh press clears the count; returning from an aborted release resumes it.
    always_comb begin
      w_rpt_nxt   = r_rpt;
      w_rpt_pulse = 1'b0;
      if (r_state == ST_CHK_DOWN && w_state_nxt == ST_DOWN) begin
        w_rpt_nxt = '0;
      end else if (r_state == ST_DOWN && w_state_nxt == ST_DOWN && w_tick) begin
        if (w_rpt_inc == c_RPT_WRAP) begin
          w_rpt_nxt   = c_RPT_DELAY;
          w_rpt_pulse = 1'b1;
        end else begin
          w_rpt_nxt   = w_rpt_inc;
          w_rpt_pulse = (w_rpt_inc == c_RPT_DELAY);
        end
      end
    end

    assign w_press_vec[gi] = w_press | w_rpt_pulse;
`else
    assign w_press_vec[gi] = w_press;
`endif
  end

  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      KEY_STATE   <= '0;
      KEY_PRESS   <= '0;
      KEY_RELEASE <= '0;
      KEY_ANY     <= 1'b0;
    end else begin
      KEY_STATE   <= w_level_nxt;
      KEY_PRESS   <= w_press_vec;
      KEY_RELEASE <= w_release_vec;
      KEY_ANY     <= |w_level_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_key_debounce_scan.sv
// tb_key_debounce_scan: directed checks of debounce latency, glitch rejection, pulses and reset.
`default_nettype none

module tb_key_debounce_scan;

  logic       clk;
  logic       rst;
  logic [7:0] r_key;
  logic [7:0] w_key_state;
  logic [7:0] w_key_press;
  logic [7:0] w_key_release;
  logic       w_key_any;

  int checks;
  int errors;

  key_debounce_scan #(
    .KEY_NUM           (8),
    .TICK_CYCLES       (4),
    .DEBOUNCE_TICKS    (3),
    .REPEAT_DELAY_TICKS(5),
    .REPEAT_RATE_TICKS (2)
  ) dut (
    .CLK_50M    (clk),
    .RST        (rst),
    .KEY        (r_key),
    .KEY_STATE  (w_key_state),
    .KEY_PRESS  (w_key_press),
    .KEY_RELEASE(w_key_release),
    .KEY_ANY    (w_key_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst   = 1'b1;
    r_key = 8'hFF;
    repeat (3) @(negedge clk);
    checks++;
    if ({w_key_state, w_key_press, w_key_release, w_key_any} !== 25'd0) begin
      errors++;
      $display("FAIL reset_out: got %h expected 0", {w_key_state, w_key_press, w_key_release, w_key_any});
    end
    rst = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      checks++;
      if ({w_key_state, w_key_press, w_key_release, w_key_any} !== 25'd0) begin
        errors++;
        $display("FAIL idle_out cycle %0d: got %h expected 0", n, {w_key_state, w_key_press, w_key_release, w_key_any});
      end
    end
  endtask

  // Pin change at a negedge: accept lands 12..15 edges later with 4-cycle ticks, 3 debounce ticks.
  task automatic test_press();
    int lat;
    lat = 0;
    r_key[2] = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (w_key_state[2]) begin
        lat = n;
        break;
      end
      checks++;
      if (w_key_press !== 8'h00) begin
        errors++;
        $display("FAIL press_early: got %h expected 00 at %0d", w_key_press, n);
      end
    end
    checks++;
    if (lat < 11 || lat > 15) begin
      errors++;
      $display("FAIL press_latency: got %0d expected 11..15", lat);
    end
    checks++;
    if (w_key_press !== 8'h04 || w_key_any !== 1'b1 || w_key_state !== 8'h04) begin
      errors++;
      $display("FAIL press_pulse: got press %h any %b state %h expected 04 1 04", w_key_press, w_key_any, w_key_state);
    end
    @(negedge clk);
    checks++;
    if (w_key_press !== 8'h00 || w_key_state !== 8'h04) begin
      errors++;
      $display("FAIL press_one_cycle: got press %h state %h expected 00 04", w_key_press, w_key_state);
    end
  endtask

  task automatic test_release();
    int lat;
    lat = 0;
    r_key[2] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (!w_key_state[2]) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat < 11 || lat > 15) begin
      errors++;
      $display("FAIL release_latency: got %0d expected 11..15", lat);
    end
    checks++;
    if (w_key_release !== 8'h04 || w_key_any !== 1'b0 || w_key_press !== 8'h00) begin
      errors++;
      $display("FAIL release_pulse: got rel %h any %b press %h expected 04 0 00", w_key_release, w_key_any, w_key_press);
    end
    @(negedge clk);
    checks++;
    if (w_key_release !== 8'h00 || w_key_state !== 8'h00) begin
      errors++;
      $display("FAIL release_one_cycle: got rel %h state %h expected 00 00", w_key_release, w_key_state);
    end
  endtask

  task automatic test_glitch();
    for (int t = 0; t < 105; t++) begin
      @(negedge clk);
      checks++;
      if (w_key_press !== 8'h00 || w_key_state !== 8'h00) begin
        errors++;
        $display("FAIL glitch cycle %0d: got press %h state %h expected 00 00", t, w_key_press, w_key_state);
      end
      if (t < 100 && (t % 5) == 0) r_key[5] = ~r_key[5];
    end
  endtask

  task automatic test_simultaneous();
    bit seen;
    seen = 1'b0;
    r_key[0] = 1'b0;
    r_key[7] = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (w_key_press !== 8'h00) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || w_key_press !== 8'h81 || w_key_state !== 8'h81) begin
      errors++;
      $display("FAIL simul_press: got press %h state %h expected 81 81", w_key_press, w_key_state);
    end
    @(negedge clk);
    checks++;
    if (w_key_press !== 8'h00) begin
      errors++;
      $display("FAIL simul_one_cycle: got %h expected 00", w_key_press);
    end
    seen = 1'b0;
    r_key[0] = 1'b1;
    r_key[7] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (w_key_release !== 8'h00) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || w_key_release !== 8'h81 || w_key_any !== 1'b0) begin
      errors++;
      $display("FAIL simul_release: got rel %h any %b expected 81 0", w_key_release, w_key_any);
    end
  endtask

  // Tick counter restarts at reset, so re-acceptance after reset release is exactly 12 edges.
  task automatic test_reset_mid();
    int lat;
    lat = 0;
    r_key[1] = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (w_key_state !== 8'h02 || w_key_any !== 1'b1) begin
      errors++;
      $display("FAIL mid_held: got state %h any %b expected 02 1", w_key_state, w_key_any);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({w_key_state, w_key_press, w_key_release, w_key_any} !== 25'd0) begin
      errors++;
      $display("FAIL mid_async_reset: got %h expected 0", {w_key_state, w_key_press, w_key_release, w_key_any});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (w_key_press[1]) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != 12 || w_key_press !== 8'h02) begin
      errors++;
      $display("FAIL mid_repress: got latency %0d press %h expected 12 02", lat, w_key_press);
    end
    r_key[1] = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (w_key_state !== 8'h00) begin
      errors++;
      $display("FAIL mid_released: got %h expected 00", w_key_state);
    end
  endtask

`ifdef KEY_REPEAT_EN
  // Pulses at accept, +5 ticks (20 clocks), then every 2 ticks (8 clocks).
  task automatic test_repeat();
    int times[4];
    int cnt;
    cnt = 0;
    r_key[3] = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (w_key_press[3] && cnt < 4) begin
        times[cnt] = n;
        cnt++;
      end
    end
    checks++;
    if (cnt != 4 || times[1] - times[0] != 20 || times[2] - times[1] != 8 || times[3] - times[2] != 8) begin
      errors++;
      $display("FAIL repeat_timing: got count %0d times %0d %0d %0d %0d expected gaps 20 8 8",
               cnt, times[0], times[1], times[2], times[3]);
    end
    checks++;
    if (w_key_state !== 8'h08) begin
      errors++;
      $display("FAIL repeat_state: got %h expected 08", w_key_state);
    end
    r_key[3] = 1'b1;
    repeat (20) @(negedge clk);
  endtask
`else
  task automatic test_no_repeat();
    int cnt;
    cnt = 0;
    r_key[3] = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (w_key_press[3]) cnt++;
    end
    checks++;
    if (cnt != 1 || w_key_state !== 8'h08) begin
      errors++;
      $display("FAIL single_press: got count %0d state %h expected 1 08", cnt, w_key_state);
    end
    r_key[3] = 1'b1;
    repeat (20) @(negedge clk);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_press();
    test_release();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
`ifdef KEY_REPEAT_EN
    test_repeat();
`else
    test_no_repeat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
